// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus a four-state stability FSM that turns a bouncing switch into a clean level
// with one-cycle rise/fall pulses. Define DEBOUNCE_ACTIVE_LOW_EN to invert Din_raw for pull-up pushbuttons.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Din_raw,
  output logic Dout,
  output logic Rise_pulse,
  output logic Fall_pulse
);

  localparam logic [1:0] ST_STABLE_LO = 2'd0;
  localparam logic [1:0] ST_WAIT_HI   = 2'd1;
  localparam logic [1:0] ST_STABLE_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO   = 2'd3;

  localparam logic [1:0]       RST_STATE = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             din_eff;
  logic             sync1_q, sync2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  assign din_eff = ~Din_raw;
`else
  assign din_eff = Din_raw;
`endif

  // The FSM only ever looks at sync2_q; sync1_q absorbs metastability.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE_LO: begin
        if (sync2_q) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!sync2_q) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE_HI: begin
        if (!sync2_q) begin
          state_d = ST_WAIT_LO;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (sync2_q) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      state_q <= RST_STATE;
      cnt_q   <= '0;
      dout_q  <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= din_eff;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign Dout       = dout_q;
  assign Rise_pulse = rise_q;
  assign Fall_pulse = fall_q;

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions a raw, bouncing mechanical switch or button input into a clean, single-clock-domain logic level.
- Sits directly upstream of the single-bit gate stages in the Xilinx simulation set: `Dout` drives their data input in board-level top files.
- Also emits one-cycle rise and fall pulses for downstream counters and toggles.

Parameters:
- STABLE_CYCLES, 16: consecutive synchronized cycles the new level must hold before `Dout` changes. Legal range ≥ 1.
- CNT_W, 5: stability counter width. Must satisfy 2^CNT_W > STABLE_CYCLES.
- RESET_LEVEL, 0: value loaded into the synchronizer flops and `Dout` at reset.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Din_raw  input  1  raw switch input; asynchronous to `Clk`, may bounce.
- Dout  output  1  debounced level, registered.
- Rise_pulse  output  1  high for exactly one cycle when `Dout` goes 0→1.
- Fall_pulse  output  1  high for exactly one cycle when `Dout` goes 1→0.

Behaviour:
- Interface: one clock, `Clk`. Reset is asynchronous and active-low on `Rst_n`.
- Reset (`Rst_n`=0, immediate, no clock needed):
  - `sync1` and `sync2` = RESET_LEVEL; `Dout` = RESET_LEVEL.
  - `Rise_pulse` = `Fall_pulse` = 0; `cnt` = 0.
  - State = STABLE_LO if RESET_LEVEL=0, else STABLE_HI.
- Reset release takes effect on the next rising edge. No pulse is generated by reset itself.
- Synchronizer: two-flop chain `Din_raw`→`sync1`→`sync2`. The FSM uses only `sync2`, called `s` below.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. Encoding is free.
  - STABLE_LO: `s`=1 → WAIT_HI, `cnt`←0. Otherwise stay.
  - WAIT_HI:
    - `s`=0 → STABLE_LO, `cnt`←0 (glitch rejected, no output change).
    - `s`=1 and `cnt`=STABLE_CYCLES-1 → STABLE_HI, `Dout`←1, `Rise_pulse`←1.
    - Otherwise `cnt`←`cnt`+1.
  - STABLE_HI / WAIT_LO: mirror of the above with levels inverted. The commit sets `Dout`←0 and `Fall_pulse`←1.
- Pulses are registered, last exactly one cycle, and are deasserted on every cycle without a commit. `Rise_pulse` and `Fall_pulse` are never high together.
- Latency:
  - A level applied to `Din_raw` before edge k and held thereafter sets `Dout` at edge k+STABLE_CYCLES+2.
  - The pulse is asserted in the same cycle that `Dout` changes.
  - Example: STABLE_CYCLES=4 gives a 6-edge latency.
- Glitch rule: a level change visible on `s` for ≤ STABLE_CYCLES consecutive cycles never alters `Dout`.
- Counter:
  - Never exceeds STABLE_CYCLES-1 and never wraps.
  - Holds 0 in STABLE_LO and STABLE_HI.
- Simultaneous events: a bounce back on the same edge as a would-be commit cannot occur, because a commit requires `s` at the new level on that edge. The transition table covers all cases.
- Reset mid-operation: reset during WAIT_* aborts the wait. Outputs return to reset values immediately, with no pulse.

Optional Feature:
- Macro: DEBOUNCE_ACTIVE_LOW_EN.
- Defined: `Din_raw` is inverted before `sync1`, for active-low pushbuttons with pull-ups. Pressing the button (`Din_raw`=0) yields `Dout`=1 and `Rise_pulse`. RESET_LEVEL still applies to the post-inversion value.
- Undefined: `Din_raw` feeds `sync1` directly. No other logic differs.

Test Plan:
1. Reset value: hold `Rst_n`=0 with `Din_raw` toggling, then release → `Dout`=0, `Rise_pulse`=`Fall_pulse`=0, no pulse on the release edge. Assert `Rst_n` mid-clock-cycle → outputs clear without waiting for an edge.
2. Clean press (STABLE_CYCLES=4): `Din_raw` 0→1 before edge 10, held high → `Dout`=1 and `Rise_pulse`=1 at edge 16 only, `Rise_pulse`=0 at edge 17.
3. Bounce rejection (STABLE_CYCLES=4): `Din_raw` high for 3 cycles, low for 2, high for 4, then low → `Dout` stays 0 and no pulses throughout.
4. Release after bounce: from `Dout`=1, toggle `Din_raw` 1/0 every cycle for 10 cycles, then hold 0 → exactly one `Fall_pulse`, asserted STABLE_CYCLES+2 edges after the final 0 is first sampled.
5. Reset mid-wait: `Din_raw`→1, assert `Rst_n`=0 two edges before the commit, release with `Din_raw` still 1 → `Dout` stays 0 until a full STABLE_CYCLES+2 edges after release, then a single `Rise_pulse`.
6. With DEBOUNCE_ACTIVE_LOW_EN defined: hold `Din_raw`=1 at reset, drive 0 (press) → `Dout`=1 and `Rise_pulse` after STABLE_CYCLES+2 edges. Drive 1 (release) → `Fall_pulse`.
